// File: rtl/sfixed_pkg.sv
// Shared fixed-point helpers: Q-format widths, divider FSM states and
// saturation constants used by sfixed_div and the multiplier.
package sfixed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int sfixed_width(input int left, input int right);
        return left + right + 1;
    endfunction

    // Largest positive value of a w-bit two's complement number.
    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative w-bit two's complement number.
    function automatic logic [63:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sfixed_div_core.sv
// Unsigned restoring division datapath: one quotient bit per clock.
// q_next/last expose the final quotient combinationally in the last cycle.
module sfixed_div_core #(
    parameter int ITER = 20,
    parameter int DW   = 12
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ITER-1:0] n_in,
    input  logic [DW-1:0]   d_in,
    output logic            last,
    output logic [ITER-1:0] q_next
);

    localparam int CW = $clog2(ITER + 1);

    logic [ITER-1:0] n_sh;
    logic [ITER-1:0] q;
    logic [DW-1:0]   d_r;
    logic [DW-1:0]   rem;
    logic [CW-1:0]   cnt;
    logic            busy;
    logic [DW:0]     trial;
    logic [DW:0]     diff;
    logic            qbit;

    always_comb begin
        trial  = {rem, n_sh[ITER-1]};
        diff   = trial - {1'b0, d_r};
        qbit   = (trial >= {1'b0, d_r});
        q_next = {q[ITER-2:0], qbit};
        last   = busy && (cnt == '0);
    end

    // The remainder always stays below D, so it fits back into DW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            n_sh <= '0;
            q    <= '0;
            d_r  <= '0;
            rem  <= '0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            n_sh <= n_in;
            d_r  <= d_in;
            q    <= '0;
            rem  <= '0;
            cnt  <= CW'(ITER - 1);
        end else if (busy) begin
            n_sh <= n_sh << 1;
            rem  <= qbit ? diff[DW-1:0] : trial[DW-1:0];
            q    <= q_next;
            cnt  <= cnt - 1'b1;
            if (last)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/sfixed_div.sv
// Iterative signed fixed-point divider out = a / b with valid/ready handshake.
// Define SFIXED_DIV_SAT_EN to saturate on overflow instead of wrapping.
module sfixed_div
    import sfixed_pkg::*;
#(
    parameter int A_LEFT    = 3,
    parameter int A_RIGHT   = 4,
    parameter int B_LEFT    = 3,
    parameter int B_RIGHT   = 4,
    parameter int OUT_LEFT  = 7,
    parameter int OUT_RIGHT = 8
)(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [sfixed_width(A_LEFT, A_RIGHT)-1:0]      a,
    input  logic [sfixed_width(B_LEFT, B_RIGHT)-1:0]      b,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [sfixed_width(OUT_LEFT, OUT_RIGHT)-1:0]  out,
    output logic                                          overflow,
    output logic                                          div_zero
);

    localparam int AW   = sfixed_width(A_LEFT, A_RIGHT);
    localparam int BW   = sfixed_width(B_LEFT, B_RIGHT);
    localparam int OW   = sfixed_width(OUT_LEFT, OUT_RIGHT);
    localparam int ITER = AW + OUT_RIGHT + B_RIGHT;
    localparam int DW   = BW + A_RIGHT;
    localparam int EW   = ((ITER > OW) ? ITER : OW) + 1;

    state_t          state, state_n;
    logic            accept, start, b_zero;
    logic [AW-1:0]   a_mag;
    logic [BW-1:0]   b_mag;
    logic [ITER-1:0] n_in;
    logic [DW-1:0]   d_in;
    logic            core_last;
    logic [ITER-1:0] q_next;
    logic            neg_r;
    logic [EW-1:0]   q_ext, pos_lim;
    logic            ovf_c;
    logic [OW-1:0]   wrap_c, res_c;

    // Unsigned magnitudes keep the most negative operand exact.
    assign a_mag  = a[AW-1] ? -a : a;
    assign b_mag  = b[BW-1] ? -b : b;
    assign b_zero = (b == '0);
    assign n_in   = ITER'(a_mag) << (OUT_RIGHT + B_RIGHT);
    assign d_in   = DW'(b_mag) << A_RIGHT;

    sfixed_div_core #(
        .ITER (ITER),
        .DW   (DW)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n_in   (n_in),
        .d_in   (d_in),
        .last   (core_last),
        .q_next (q_next)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = b_zero ? DONE : CALC;
            CALC: if (core_last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        start     = accept && !b_zero;
    end

    // A negative result may reach one step further than a positive one.
    always_comb begin
        q_ext   = EW'(q_next);
        pos_lim = EW'(sat_pos(OW));
        ovf_c   = neg_r ? (q_ext > pos_lim + EW'(1)) : (q_ext > pos_lim);
        wrap_c  = neg_r ? OW'(-q_ext) : OW'(q_ext);
        res_c   = wrap_c;
`ifdef SFIXED_DIV_SAT_EN
        if (ovf_c)
            res_c = neg_r ? OW'(sat_neg(OW)) : OW'(sat_pos(OW));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_r    <= 1'b0;
            out      <= '0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            neg_r <= a[AW-1] ^ b[BW-1];
            if (b_zero) begin
                out      <= a[AW-1] ? OW'(sat_neg(OW)) : OW'(sat_pos(OW));
                overflow <= 1'b1;
                div_zero <= 1'b1;
            end
        end else if ((state == CALC) && core_last) begin
            out      <= res_c;
            overflow <= ovf_c;
            div_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sfixed_div.sv
// Self-checking bench for sfixed_div at default Q formats; reference model
// uses plain signed integer division on the real-valued operands.
module tb_sfixed_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        overflow;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

    sfixed_div #(
        .A_LEFT    (3),
        .A_RIGHT   (4),
        .B_LEFT    (3),
        .B_RIGHT   (4),
        .OUT_LEFT  (7),
        .OUT_RIGHT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // a and b are Q3.4; the quotient in Q7.8 is trunc(a_int * 2^8 / b_int).
    function automatic void model(input logic [7:0] ta, input logic [7:0] tbv,
                                  output logic [15:0] eo, output logic eovf, output logic edz);
        longint av, bv, r;
        av = longint'($signed(ta));
        bv = longint'($signed(tbv));
        if (bv == 0) begin
            edz  = 1'b1;
            eovf = 1'b1;
            eo   = (av >= 0) ? 16'h7FFF : 16'h8000;
        end else begin
            edz  = 1'b0;
            r    = (av * 256) / bv;
            eovf = (r > 32767) || (r < -32768);
            eo   = r[15:0];
`ifdef SFIXED_DIV_SAT_EN
            if (eovf)
                eo = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        end
    endfunction

    task automatic run_div(input logic [7:0] ta, input logic [7:0] tbv,
                           input int hold, input string tag);
        logic [15:0] eo, held;
        logic        eovf, edz;
        int          lat;
        bit          ok;
        model(ta, tbv, eo, eovf, edz);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check_eq({tag, "_valid_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, "_latency"}, lat, (tbv == 8'h00) ? 32'd1 : 32'd21);
        check_eq({tag, "_out"}, out, eo);
        check_eq({tag, "_overflow"}, overflow, eovf);
        check_eq({tag, "_div_zero"}, div_zero, edz);
        held = out;
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_out"}, out, held);
            check_eq({tag, "_hold_in_ready"}, in_ready, 1'b0);
            check_eq({tag, "_hold_valid"}, out_valid, 1'b1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, out_valid, 1'b0);
        check_eq({tag, "_back_idle"}, in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_in_ready", in_ready, 1'b0);
        end
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out", out, 16'h0000);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_div_zero", div_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1'b1);

        run_div(8'h18, 8'h08, 0, "p1p5_div_p0p5");
        run_div(8'hDC, 8'h18, 0, "m2p25_div_p1p5");
        run_div(8'h10, 8'h30, 0, "p1_div_p3");
        run_div(8'hF0, 8'h30, 0, "m1_div_p3");
        run_div(8'h80, 8'h01, 0, "minneg_exact");
        run_div(8'h80, 8'hFF, 0, "minneg_ovf");
        run_div(8'h10, 8'h00, 0, "pos_div_zero");
        run_div(8'hF0, 8'h00, 0, "neg_div_zero");
        run_div(8'hDC, 8'h18, 5, "stall5");

        // Abort an operation part-way through the iteration.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        a = 8'h18;
        b = 8'h08;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_out_valid", out_valid, 1'b0);
        check_eq("abort_in_ready", in_ready, 1'b1);
        run_div(8'h18, 8'h08, 0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_div(ra, rb, int'($urandom_range(0, 2)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
